// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - shared filter codes, scale code, FSM states and channel sequencing (COLOR_FREQ_CLEAR_EN adds clear)
package color_pkg;

    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [1:0] FILT_CLEAR = 2'b10;
    localparam logic [1:0] SCALE_100  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_PRESENT
    } state_t;

    function automatic logic [1:0] next_filter(input logic [1:0] f);
        logic [1:0] n;
        n = FILT_RED;
        case (f)
            FILT_RED:   n = FILT_BLUE;
            FILT_BLUE:  n = FILT_GREEN;
`ifdef COLOR_FREQ_CLEAR_EN
            FILT_GREEN: n = FILT_CLEAR;
`else
            FILT_GREEN: n = FILT_RED;
`endif
            default:    n = FILT_RED;
        endcase
        return n;
    endfunction

    function automatic logic is_last(input logic [1:0] f);
`ifdef COLOR_FREQ_CLEAR_EN
        return f == FILT_CLEAR;
`else
        return f == FILT_GREEN;
`endif
    endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - 2-FF synchronizer with a third stage for a one-cycle rising-edge pulse
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], din};
        end
    end

    assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/color_freq_meter.sv
// rtl/color_freq_meter.sv - color sensor filter sequencer and gated edge counter (COLOR_FREQ_CLEAR_EN adds clear channel)
module color_freq_meter
    import color_pkg::*;
#(
    parameter int GATE_CYCLES   = 1000000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_freq,
    input  logic             enable,
    output logic [1:0]       scale,
    output logic [1:0]       filter,
    output logic             enf,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       chan,
    output logic             ovf,
    output logic             valid,
    input  logic             ready,
    output logic             scan_done
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [GW-1:0]    G_LAST  = GW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0]    S_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_next;
    logic [SW-1:0]    settle_cnt;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] cnt;
    logic             ovf_r;
    logic [1:0]       chan_r;
    logic             edge_pulse;
    logic             accept;

    edge_sync u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sensor_freq),
        .rise  (edge_pulse)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE:    if (enable) state_next = ST_SETTLE;
            ST_SETTLE:  if (settle_cnt == '0) state_next = ST_GATE;
            ST_GATE:    if (gate_cnt == '0) state_next = ST_PRESENT;
            ST_PRESENT: begin
                if (ready) begin
                    accept     = 1'b1;
                    state_next = ST_SETTLE;
                end
            end
            default:    state_next = ST_IDLE;
        endcase
        // Disable overrides everything, including a handshake in the same cycle.
        if (!enable) begin
            state_next = ST_IDLE;
            accept     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            gate_cnt   <= '0;
            cnt        <= '0;
            ovf_r      <= 1'b0;
            chan_r     <= FILT_RED;
            filter     <= FILT_RED;
        end else begin
            state <= state_next;

            if (state_next == ST_SETTLE && state != ST_SETTLE) begin
                settle_cnt <= S_LAST;
                filter     <= (state == ST_IDLE) ? FILT_RED : next_filter(filter);
            end else if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            if (state == ST_SETTLE && state_next == ST_GATE) begin
                gate_cnt <= G_LAST;
                cnt      <= '0;
                ovf_r    <= 1'b0;
            end else if (state == ST_GATE) begin
                gate_cnt <= gate_cnt - 1'b1;
                if (edge_pulse) begin
                    if (cnt == CNT_MAX) ovf_r <= 1'b1;
                    else                cnt   <= cnt + 1'b1;
                end
            end

            if (state == ST_GATE && state_next == ST_PRESENT) begin
                chan_r <= filter;
            end
        end
    end

    assign scale     = SCALE_100;
    assign enf       = (state != ST_IDLE);
    assign valid     = (state == ST_PRESENT);
    assign count     = cnt;
    assign chan      = chan_r;
    assign ovf       = ovf_r;
    assign scan_done = accept && is_last(filter);

endmodule

// File: doc/color_freq_meter.md
# color_freq_meter

Front-end measurement stage for the TCS3200-style color sensor; it feeds the color classifier. It steps the sensor photodiode filter through the color channels, waits for the output to settle, and counts synchronized rising edges of the sensor frequency output over a fixed gate window. Each per-channel count is handed downstream with a valid/ready handshake.

## Interface
- GATE_CYCLES, 1000000, length of the counting window in clk cycles (≥2)
- SETTLE_CYCLES, 1000, wait after each filter change before counting (≥1)
- CNT_W, 20, width of the edge counter and count output
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low; one clock domain only
- sensor_freq  in  1  asynchronous sensor square-wave output
- enable  in  1  high: continuous scanning; low: idle
- scale  out  2  sensor frequency scaling select; constant 2'b11 (100%)
- filter  out  2  sensor filter select: 00 red, 01 blue, 11 green, 10 clear
- enf  out  1  sensor output enable; high while not IDLE
- count  out  CNT_W  edge count of the presented channel
- chan  out  2  filter code that produced count
- ovf  out  1  count saturated; qualified by valid
- valid  out  1  count/chan/ovf valid
- ready  in  1  downstream accepts when valid && ready
- scan_done  out  1  one-cycle pulse on acceptance of the last channel of a scan

## Operation
- Synchronize sensor_freq with a 2-FF synchronizer, then detect rising edges by comparing with a third register. One edge pulse is produced per input rising edge.
- State machine states: IDLE, SETTLE, GATE, PRESENT.
- IDLE → SETTLE when enable=1. filter=00, and the settle counter is loaded.
- SETTLE: count SETTLE_CYCLES cycles and ignore edges. → GATE with the edge counter cleared.
- GATE: run for exactly GATE_CYCLES cycles. Each edge pulse increments the counter. The counter saturates at 2^CNT_W−1 and sets a sticky ovf for the window. An edge in the final gate cycle is counted. → PRESENT.
- PRESENT: valid=1. count, chan and ovf are held stable, and edges are ignored. On valid && ready, advance filter to the next channel and go to SETTLE. If the accepted channel was the last one, pulse scan_done and go back to red.
- Channel sequence: 00 → 01 → 11 → (00).
- enable=0 in any state moves to IDLE on the next edge. valid drops, no scan_done, any partial count is discarded. Re-enable always restarts at red.
- The filter output changes only on the SETTLE entry edge.

## Timing
- Reset values: scale=2'b11, filter=2'b00, enf=0, count=0, chan=2'b00, ovf=0, valid=0, scan_done=0, state IDLE.
- Edge path latency: 3 clk from sensor_freq rise to counter increment.
- Per-channel latency, measured from SETTLE entry: SETTLE_CYCLES + GATE_CYCLES cycles, then valid rises on the next edge.
- With ready held high, valid is high for exactly one cycle per channel.
- scan_done is asserted in the same cycle as the accepting handshake, never while enable=0.
- Reset mid-operation: all outputs take their reset values on the next edge.

## Configuration
- COLOR_FREQ_CLEAR_EN defined: the sequence is 00 → 01 → 11 → 10, and the clear channel is last before scan_done.
- Not defined: three-channel sequence. filter never equals 10.

## Structure
- Shared package color_pkg holds:
  - filter code constants (FILT_RED, FILT_BLUE, FILT_GREEN, FILT_CLEAR)
  - SCALE_100 constant
  - the state enum
- Sub-module edge_sync: 2-FF synchronizer plus rising-edge pulse, with rst_n.

## Test plan
All scenarios use GATE_CYCLES=100, SETTLE_CYCLES=4, CNT_W=20 unless stated.
- Reset: hold rst_n=0 with enable=1 and a toggling input → all outputs at reset values, enf=0.
- Normal scan: sensor_freq period 10 clk, enable=1, ready=1 → three valids with chan 00, 01, 11, count 10±1 each, ovf=0, scan_done coincident with the chan 11 handshake.
- Backpressure: ready=0 for 50 cycles in PRESENT → valid stays high, count/chan stable, filter unchanged. The transfer completes on the cycle ready rises.
- Saturation: CNT_W=4, period 2 clk → count=15, ovf=1. The next channel, with input held low, gives count=0, ovf=0.
- Abort: drop enable at gate cycle 50 → IDLE next cycle, enf=0, no valid. Re-enable → filter=00, and the first count is a full 100-cycle window.
- Macro: with COLOR_FREQ_CLEAR_EN, chan sequence is 00, 01, 11, 10, and scan_done occurs on the 10 handshake.
